// File: rtl/span_fill.sv
// Span responder: turns one (start_x, end_x, y, colour) request into a run of framebuffer pixel writes.
// Optional statistics outputs (pix_count, drop_count) are enabled by defining SPAN_FILL_STATS_EN.
module span_fill #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               draw,
  input  logic [10:0]        start_x,
  input  logic [10:0]        end_x,
  input  logic [15:0]        y_coord,
  input  logic [COLOR_W-1:0] color,
  input  logic               pix_ready,
  output logic               pix_valid,
  output logic [ADDR_W-1:0]  pix_addr,
  output logic [COLOR_W-1:0] pix_data,
  output logic               busy,
`ifdef SPAN_FILL_STATS_EN
  output logic [31:0]        pix_count,
  output logic [15:0]        drop_count,
`endif
  output logic               bresenham_done
);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

  localparam logic [10:0] X_LIM = 11'(H_RES);
  localparam logic [10:0] X_MAX = 11'(H_RES - 1);
  localparam logic [15:0] Y_LIM = 16'(V_RES);

  state_t            state;
  logic [10:0]       sx;
  logic [10:0]       ex;
  logic [15:0]       y_lat;
  logic [10:0]       x;
  logic [10:0]       hi;

  logic [10:0]       lo_c;
  logic [10:0]       hi_c;
  logic [10:0]       hi_clamp;
  logic              empty_c;
  logic [ADDR_W-1:0] base_c;
  logic              beat;

  // Span ordering, clamping and base-address product, consumed in SETUP.
  always_comb begin
    lo_c     = (sx <= ex) ? sx : ex;
    hi_c     = (sx <= ex) ? ex : sx;
    hi_clamp = (hi_c > X_MAX) ? X_MAX : hi_c;
    empty_c  = (y_lat >= Y_LIM) || (lo_c >= X_LIM);
    base_c   = ADDR_W'(y_lat) * ADDR_W'(H_RES) + ADDR_W'(lo_c);
  end

  assign beat = pix_valid & pix_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      sx             <= '0;
      ex             <= '0;
      y_lat          <= '0;
      x              <= '0;
      hi             <= '0;
      pix_valid      <= 1'b0;
      pix_addr       <= '0;
      pix_data       <= '0;
      busy           <= 1'b0;
      bresenham_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (draw) begin
            sx             <= start_x;
            ex             <= end_x;
            y_lat          <= y_coord;
            pix_data       <= color;
            bresenham_done <= 1'b0;
            busy           <= 1'b1;
            state          <= SETUP;
          end
        end
        SETUP: begin
          if (empty_c) begin
            state <= DONE;
          end else begin
            x         <= lo_c;
            hi        <= hi_clamp;
            pix_addr  <= base_c;
            pix_valid <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          // Outputs only move on an accepted beat, so they hold under backpressure.
          if (beat) begin
            if (x == hi) begin
              pix_valid <= 1'b0;
              state     <= DONE;
            end else begin
              x        <= x + 11'd1;
              pix_addr <= pix_addr + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          busy           <= 1'b0;
          bresenham_done <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPAN_FILL_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_count  <= '0;
      drop_count <= '0;
    end else begin
      if (beat) pix_count <= pix_count + 32'd1;
      if (draw && (state != IDLE) && (drop_count != 16'hFFFF))
        drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_span_fill.sv
// Scoreboard bench for span_fill: stimulus pushes expected beats, a negedge monitor pops and compares.
// Statistics checks are compiled in when SPAN_FILL_STATS_EN is defined.
module tb_span_fill;
  localparam int ADDR_W  = 19;
  localparam int COLOR_W = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               draw;
  logic [10:0]        start_x;
  logic [10:0]        end_x;
  logic [15:0]        y_coord;
  logic [COLOR_W-1:0] color;
  logic               pix_ready;
  logic               pix_valid;
  logic [ADDR_W-1:0]  pix_addr;
  logic [COLOR_W-1:0] pix_data;
  logic               busy;
  logic               bresenham_done;
`ifdef SPAN_FILL_STATS_EN
  logic [31:0]        pix_count;
  logic [15:0]        drop_count;
`endif

  span_fill dut (
    .clk            (clk),
    .reset          (reset),
    .draw           (draw),
    .start_x        (start_x),
    .end_x          (end_x),
    .y_coord        (y_coord),
    .color          (color),
    .pix_ready      (pix_ready),
    .pix_valid      (pix_valid),
    .pix_addr       (pix_addr),
    .pix_data       (pix_data),
    .busy           (busy),
`ifdef SPAN_FILL_STATS_EN
    .pix_count      (pix_count),
    .drop_count     (drop_count),
`endif
    .bresenham_done (bresenham_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] data;
    int                 cyc;
  } beat_t;

  beat_t             sb[$];
  beat_t             exp_beat;
  int                compared   = 0;
  int                mismatched = 0;
  int                beats      = 0;
  logic              hold_prev  = 1'b0;
  logic [ADDR_W-1:0] addr_prev  = '0;
  bit                pat[6]     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: sampled on the falling edge, so each valid&ready seen here is the beat taken at the next rising edge.
  always @(negedge clk) begin
    if (hold_prev) begin
      check("hold_valid", 64'(pix_valid), 64'd1);
      check("hold_addr", 64'(pix_addr), 64'(addr_prev));
    end
    if (reset && pix_valid && pix_ready) begin
      beats++;
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_beat: got addr %0d, expected no beat (cycle %0d)", pix_addr, cyc);
      end else begin
        exp_beat = sb.pop_front();
        check("beat_addr", 64'(pix_addr), 64'(exp_beat.addr));
        check("beat_data", 64'(pix_data), 64'(exp_beat.data));
        if (exp_beat.cyc >= 0) check("beat_cycle", 64'(cyc), 64'(exp_beat.cyc));
      end
    end
    hold_prev = reset && pix_valid && !pix_ready;
    addr_prev = pix_addr;
  end

  task automatic do_draw(input logic [10:0] sx, input logic [10:0] ex, input logic [15:0] y,
                         input logic [7:0] c, output int k);
    @(posedge clk); #1;
    draw = 1'b1; start_x = sx; end_x = ex; y_coord = y; color = c;
    k = cyc;
    @(posedge clk); #1;
    draw = 1'b0;
    @(negedge clk);
    check("busy_after_draw", 64'(busy), 64'd1);
    check("done_cleared", 64'(bresenham_done), 64'd0);
  endtask

  task automatic push_span(input int base, input int n, input logic [7:0] c, input int k, input bit timed);
    for (int i = 0; i < n; i++)
      sb.push_back('{addr: ADDR_W'(base + i), data: c, cyc: timed ? (k + 2 + i) : -1});
  endtask

  task automatic wait_done(input int exp_cyc, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bresenham_done && n < 60);
    if (!bresenham_done) begin
      compared++;
      mismatched++;
      $display("FAIL %s: got no bresenham_done, expected it at cycle %0d", name, exp_cyc);
    end else begin
      check(name, 64'(cyc), 64'(exp_cyc));
      check({name, "_busy"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int b0;
    reset = 1'b0; draw = 1'b0; start_x = '0; end_x = '0; y_coord = '0; color = '0; pix_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(pix_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(bresenham_done), 64'd0);
    check("rst_addr", 64'(pix_addr), 64'd0);
    check("rst_data", 64'(pix_data), 64'd0);
`ifdef SPAN_FILL_STATS_EN
    check("rst_pix_count", 64'(pix_count), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
`endif
    reset = 1'b1;

    // Basic span 10..13 on row 2.
    do_draw(11'd10, 11'd13, 16'd2, 8'h5A, k);
    push_span(1290, 4, 8'h5A, k, 1'b1);
    wait_done(k + 7, "basic_done");
    repeat (3) @(negedge clk);
    check("done_level", 64'(bresenham_done), 64'd1);

    // Reversed pair, right end clamped to 639.
    do_draw(11'd700, 11'd636, 16'd0, 8'hC3, k);
    push_span(636, 4, 8'hC3, k, 1'b1);
    wait_done(k + 7, "clamp_done");

    // Backpressure on span 0..2, row 1.
    b0 = beats;
    do_draw(11'd0, 11'd2, 16'd1, 8'h11, k);
    push_span(640, 3, 8'h11, k, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      pix_ready = pat[i];
    end
    wait_done(k + 9, "bp_done");
    check("bp_beats", 64'(beats - b0), 64'd3);

    // Off-screen row; a draw during the DONE cycle is ignored.
    b0 = beats;
    do_draw(11'd5, 11'd9, 16'd480, 8'h22, k);
    @(posedge clk); #1;
    draw = 1'b1;
    @(posedge clk); #1;
    draw = 1'b0;
    wait_done(k + 3, "empty_y_done");
    repeat (4) @(negedge clk);
    check("empty_y_busy", 64'(busy), 64'd0);
    check("empty_y_beats", 64'(beats - b0), 64'd0);
`ifdef SPAN_FILL_STATS_EN
    check("drop_after_done_draw", 64'(drop_count), 64'd1);
`endif

    // Off-screen x.
    b0 = beats;
    do_draw(11'd640, 11'd640, 16'd5, 8'h33, k);
    wait_done(k + 3, "empty_x_done");
    check("empty_x_beats", 64'(beats - b0), 64'd0);

    // Single pixel in the bottom-right corner.
    do_draw(11'd639, 11'd639, 16'd479, 8'hFF, k);
    push_span(307199, 1, 8'hFF, k, 1'b1);
    wait_done(k + 4, "single_done");

    // Draw while running is ignored.
    do_draw(11'd100, 11'd109, 16'd3, 8'h77, k);
    push_span(2020, 10, 8'h77, k, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    draw = 1'b1; start_x = 11'd0; end_x = 11'd5; y_coord = 16'd0; color = 8'h99;
    @(posedge clk); #1;
    draw = 1'b0;
    wait_done(k + 13, "busy_draw_done");
`ifdef SPAN_FILL_STATS_EN
    check("drop_count", 64'(drop_count), 64'd2);
    check("pix_count", 64'(pix_count), 64'(beats));
`endif

    // Asynchronous reset in the middle of a run.
    do_draw(11'd0, 11'd20, 16'd10, 8'h3C, k);
    push_span(6400, 21, 8'h3C, k, 1'b1);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    sb.delete();
    #1;
    check("async_rst_valid", 64'(pix_valid), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_done", 64'(bresenham_done), 64'd0);
    check("async_rst_addr", 64'(pix_addr), 64'd0);
`ifdef SPAN_FILL_STATS_EN
    check("async_rst_pix_count", 64'(pix_count), 64'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Normal operation after reset release.
    do_draw(11'd10, 11'd13, 16'd2, 8'hA5, k);
    push_span(1290, 4, 8'hA5, k, 1'b1);
    wait_done(k + 7, "post_rst_done");

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
